// File: rtl/return_pkt_scheduler_pkg.sv
// Shared types and constants for the ARM return-packet scheduler.
// Holds the FSM encoding, source IDs, packet words and the round-robin pick.
package return_pkt_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR0     = 2'd1,
        WR1     = 2'd2,
        WAIT_RD = 2'd3
    } state_t;

    localparam logic [1:0] SRC_PARA   = 2'd0;
    localparam logic [1:0] SRC_MODE   = 2'd1;
    localparam logic [1:0] SRC_UPLOAD = 2'd2;
    localparam logic [1:0] SRC_NONE   = 2'd3;

    localparam logic [15:0] HDR_PARA   = 16'h2222;
    localparam logic [15:0] PAY_PARA   = 16'h5555;
    localparam logic [15:0] HDR_MODE   = 16'h4444;
    localparam logic [15:0] HDR_UPLOAD = 16'h8888;

    // First pending source strictly after last, wrapping over 0..2.
    function automatic logic [1:0] rr_pick(
        input logic [2:0] pend,
        input logic [1:0] last
    );
        logic [1:0] pick;
        logic [1:0] idx;
        pick = SRC_NONE;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % 3);
            if (pend[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/return_pkt_scheduler_cs_edge_sync.sv
// CSn synchronizer with a one-cycle rising-edge pulse.
// All flops idle high so a released CSn never looks like an edge.
module cs_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= cs_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/return_pkt_scheduler.sv
// Arbitrates three return-packet requests and writes each packet to the
// ARM read RAM, then waits for the ARM to read it or for a timeout.
module return_pkt_scheduler
    import return_pkt_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int READ_EDGES  = 4
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic        CSn,
    input  logic        para_confi_acq_flag,
    input  logic        mode_sel_acq_flag,
    input  logic [15:0] mode_payload,
    input  logic        data_upload_acq_flag,
    input  logic [15:0] upload_payload,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_en,
    output logic        fpga_to_arm,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t        state;
    state_t        state_nx;
    logic [2:0]    pend;
    logic [2:0]    flags;
    logic [2:0]    clr;
    logic [15:0]   mode_pay;
    logic [15:0]   up_pay;
    logic [15:0]   hdr;
    logic [15:0]   pay;
    logic [1:0]    last;
    logic [1:0]    gid;
    logic [1:0]    gnt;
    logic          go;
    logic          rise;
    logic          done;
    logic          tmo;
    logic [2:0]    rcnt;
    logic [TW-1:0] tcnt;

    cs_edge_sync u_sync (
        .clk  (clk_25m),
        .rst  (rst),
        .cs_n (CSn),
        .rise (rise)
    );

    assign flags = {data_upload_acq_flag, mode_sel_acq_flag, para_confi_acq_flag};
    assign gnt   = rr_pick(pend, last);
    assign go    = (state == IDLE) && (|pend);
    assign clr   = go ? (3'b001 << gnt) : 3'b000;
    assign done  = (state == WAIT_RD) && rise && (rcnt == 3'(READ_EDGES - 1));
    assign tmo   = (state == WAIT_RD) && (tcnt == TW'(TIMEOUT_CYC - 1));

    assign fpga_to_arm = (state == WAIT_RD);
    assign busy        = (state != IDLE);
    assign grant_id    = gid;

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 16'h0000;
        unique case (state)
            IDLE:    if (|pend) state_nx = WR0;
            WR0: begin
                state_nx = WR1;
                wr_en    = 1'b1;
                wr_data  = hdr;
            end
            WR1: begin
                state_nx = WAIT_RD;
                wr_en    = 1'b1;
                wr_addr  = 5'd1;
                wr_data  = pay;
            end
            WAIT_RD: if (done || tmo) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= 3'b000;
            mode_pay    <= 16'h0000;
            up_pay      <= 16'h0000;
            hdr         <= 16'h0000;
            pay         <= 16'h0000;
            last        <= SRC_UPLOAD;
            gid         <= SRC_NONE;
            rcnt        <= 3'd0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            // A flag in the grant cycle re-queues its source.
            pend  <= (pend & ~clr) | flags;
            if (mode_sel_acq_flag)    mode_pay <= mode_payload;
            if (data_upload_acq_flag) up_pay   <= upload_payload;
            if (go) begin
                gid  <= gnt;
                last <= gnt;
                unique case (gnt)
                    SRC_PARA: begin
                        hdr <= HDR_PARA;
                        pay <= PAY_PARA;
                    end
                    SRC_MODE: begin
                        hdr <= HDR_MODE;
                        pay <= mode_pay;
                    end
                    default: begin
                        hdr <= HDR_UPLOAD;
                        pay <= up_pay;
                    end
                endcase
            end else if (state_nx == IDLE) begin
                gid <= SRC_NONE;
            end
            if (state == WAIT_RD) begin
                tcnt <= tcnt + 1'b1;
                if (rise) rcnt <= rcnt + 1'b1;
            end else begin
                tcnt <= '0;
                rcnt <= 3'd0;
            end
            if (tmo && !done) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_return_pkt_scheduler.sv
// Self-checking bench: vector table of single requests plus hand-written
// multi-cycle sequences, with a scoreboard on the RAM write port.
module tb_return_pkt_scheduler;

    logic        clk_25m;
    logic        rst;
    logic        CSn;
    logic        para_confi_acq_flag;
    logic        mode_sel_acq_flag;
    logic [15:0] mode_payload;
    logic        data_upload_acq_flag;
    logic [15:0] upload_payload;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        fpga_to_arm;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic [2:0]  flags;
        logic [15:0] mp;
        logic [15:0] up;
        logic [15:0] hdr;
        logic [15:0] pay;
        logic [1:0]  gid;
    } vec_t;

    wr_t  sb[$];
    vec_t vt[5];
    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_count = 0;

    return_pkt_scheduler #(
        .TIMEOUT_CYC (100),
        .READ_EDGES  (4)
    ) dut (
        .clk_25m              (clk_25m),
        .rst                  (rst),
        .CSn                  (CSn),
        .para_confi_acq_flag  (para_confi_acq_flag),
        .mode_sel_acq_flag    (mode_sel_acq_flag),
        .mode_payload         (mode_payload),
        .data_upload_acq_flag (data_upload_acq_flag),
        .upload_payload       (upload_payload),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .wr_en                (wr_en),
        .fpga_to_arm          (fpga_to_arm),
        .busy                 (busy),
        .grant_id             (grant_id),
        .timeout_err          (timeout_err)
    );

    initial clk_25m = 1'b0;
    always #20 clk_25m = ~clk_25m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk_25m) begin
        if (!rst && wr_en === 1'b1) begin
            wr_t e;
            wr_count++;
            if (sb.size() == 0) begin
                chk("unexpected_wr", {11'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_addr_data", {11'd0, wr_addr, wr_data}, {11'd0, e.a, e.d});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_pkt(input logic [15:0] h, input logic [15:0] p);
        sb.push_back('{a: 5'd0, d: h});
        sb.push_back('{a: 5'd1, d: p});
    endtask

    task automatic pulse(input logic [2:0] f, input logic [15:0] mp, input logic [15:0] up);
        @(posedge clk_25m); #1;
        para_confi_acq_flag  = f[0];
        mode_sel_acq_flag    = f[1];
        data_upload_acq_flag = f[2];
        mode_payload         = mp;
        upload_payload       = up;
        @(posedge clk_25m); #1;
        para_confi_acq_flag  = 1'b0;
        mode_sel_acq_flag    = 1'b0;
        data_upload_acq_flag = 1'b0;
    endtask

    task automatic wait_fpga();
        int n;
        n = 0;
        @(negedge clk_25m);
        while (fpga_to_arm !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk_25m);
        end
        if (fpga_to_arm !== 1'b1) chk("wait_fpga", 32'(fpga_to_arm), 32'd1);
    endtask

    task automatic cs_rise(output logic a, output logic b);
        @(posedge clk_25m); #1 CSn = 1'b0;
        @(posedge clk_25m); #1 CSn = 1'b1;
        repeat (3) @(negedge clk_25m);
        a = fpga_to_arm;
        @(negedge clk_25m);
        b = fpga_to_arm;
    endtask

    task automatic read_pkt();
        logic a;
        logic b;
        for (int i = 0; i < 4; i++) begin
            cs_rise(a, b);
            chk("fpga_at_rise", 32'(a), 32'd1);
            chk("fpga_after_rise", 32'(b), (i < 3) ? 32'd1 : 32'd0);
        end
        chk("idle_gap_wr_en", 32'(wr_en), 32'd0);
    endtask

    initial begin
        int cnt;
        int wc;
        rst = 1'b1;
        CSn = 1'b1;
        para_confi_acq_flag  = 1'b0;
        mode_sel_acq_flag    = 1'b0;
        data_upload_acq_flag = 1'b0;
        mode_payload   = 16'h0000;
        upload_payload = 16'h0000;

        vt[0] = '{3'b001, 16'h0000, 16'h0000, 16'h2222, 16'h5555, 2'd0};
        vt[1] = '{3'b010, 16'hA5A5, 16'h0000, 16'h4444, 16'hA5A5, 2'd1};
        vt[2] = '{3'b100, 16'h0000, 16'h1234, 16'h8888, 16'h1234, 2'd2};
        vt[3] = '{3'b010, 16'hFFFF, 16'hEEEE, 16'h4444, 16'hFFFF, 2'd1};
        vt[4] = '{3'b100, 16'h1111, 16'h0000, 16'h8888, 16'h0000, 2'd2};

        repeat (3) @(negedge clk_25m);
        chk("rst_outs", {16'd0, 5'(wr_addr), 1'b0, wr_en, fpga_to_arm, busy, grant_id, timeout_err, 5'd0},
            {16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 5'd0});
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        @(posedge clk_25m); #1 rst = 1'b0;

        // Single requests with exact latency checks
        for (int i = 0; i < 5; i++) begin
            push_pkt(vt[i].hdr, vt[i].pay);
            pulse(vt[i].flags, vt[i].mp, vt[i].up);
            @(negedge clk_25m);
            chk("lat_n1_wr_en", 32'(wr_en), 32'd0);
            @(negedge clk_25m);
            chk("lat_n2_wr", {wr_en, 5'(wr_addr)}, {1'b1, 5'd0});
            @(negedge clk_25m);
            chk("lat_n3_wr", {wr_en, 5'(wr_addr)}, {1'b1, 5'd1});
            @(negedge clk_25m);
            chk("lat_n4_fpga", 32'(fpga_to_arm), 32'd1);
            chk("vec_grant", {busy, grant_id}, {1'b1, vt[i].gid});
            read_pkt();
        end
        chk("idle_grant", {busy, grant_id}, {1'b0, 2'd3});

        // All three at once: round robin 0,1,2 with an idle cycle between
        push_pkt(16'h2222, 16'h5555);
        push_pkt(16'h4444, 16'h0101);
        push_pkt(16'h8888, 16'h0202);
        pulse(3'b111, 16'h0101, 16'h0202);
        for (int s = 0; s < 3; s++) begin
            wait_fpga();
            chk("simul_grant", 32'(grant_id), 32'(s));
            read_pkt();
            if (s < 2) begin
                @(negedge clk_25m);
                chk("next_wr0", 32'(wr_en), 32'd1);
            end
        end

        // Mode payload overwritten while source 0 is served
        push_pkt(16'h2222, 16'h5555);
        push_pkt(16'h4444, 16'h0022);
        pulse(3'b001, 16'h0000, 16'h0000);
        wait_fpga();
        pulse(3'b010, 16'h0011, 16'h0000);
        pulse(3'b010, 16'h0022, 16'h0000);
        read_pkt();
        wait_fpga();
        chk("ovw_grant", 32'(grant_id), 32'd1);
        read_pkt();

        // CSn edges outside WAIT_RD must not count
        push_pkt(16'h8888, 16'h0BAD);
        @(posedge clk_25m); #1 CSn = 1'b0;
        @(posedge clk_25m); #1 CSn = 1'b1;
        @(posedge clk_25m); #1 CSn = 1'b0;
        @(posedge clk_25m); #1 CSn = 1'b0;
        @(posedge clk_25m); #1;
        data_upload_acq_flag = 1'b1;
        upload_payload = 16'h0BAD;
        CSn = 1'b1;
        @(posedge clk_25m); #1 data_upload_acq_flag = 1'b0;
        wait_fpga();
        read_pkt();

        // Timeout with no CSn activity
        push_pkt(16'h8888, 16'h7777);
        pulse(3'b100, 16'h0000, 16'h7777);
        wait_fpga();
        chk("tmo_err_before", 32'(timeout_err), 32'd0);
        cnt = 0;
        while (fpga_to_arm === 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge clk_25m);
        end
        chk("tmo_cycles", 32'(cnt), 32'd100);
        chk("tmo_err_set", 32'(timeout_err), 32'd1);
        repeat (10) @(negedge clk_25m);
        chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Reset in WAIT_RD with source 2 pending
        push_pkt(16'h2222, 16'h5555);
        pulse(3'b001, 16'h0000, 16'h0000);
        wait_fpga();
        pulse(3'b100, 16'h0000, 16'h9999);
        @(posedge clk_25m); #1 rst = 1'b1;
        @(negedge clk_25m);
        chk("midrst_outs", {5'(wr_addr), wr_en, fpga_to_arm, busy, grant_id, timeout_err},
            {5'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0});
        chk("midrst_wr_data", 32'(wr_data), 32'd0);
        @(posedge clk_25m); #1 rst = 1'b0;
        wc = wr_count;
        repeat (20) @(negedge clk_25m);
        chk("no_wr_after_rst", 32'(wr_count - wc), 32'd0);

        // Pointer restarts at source 0 after reset
        push_pkt(16'h2222, 16'h5555);
        push_pkt(16'h4444, 16'h3C3C);
        pulse(3'b011, 16'h3C3C, 16'h0000);
        wait_fpga();
        chk("post_rst_grant0", 32'(grant_id), 32'd0);
        read_pkt();
        @(negedge clk_25m);
        chk("post_rst_next_wr0", 32'(wr_en), 32'd1);
        wait_fpga();
        chk("post_rst_grant1", 32'(grant_id), 32'd1);
        read_pkt();

        repeat (3) @(negedge clk_25m);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
